// File: rtl/merge_pkg.sv
// Shared constants and FIFO entry layout for the two-source merge stage.
package merge_pkg;

  localparam int unsigned DATA_W_DEFAULT = 32;

  localparam logic SRC_1 = 1'b0;
  localparam logic SRC_2 = 1'b1;

  typedef struct packed {
    logic                      src;
    logic [DATA_W_DEFAULT-1:0] data;
  } entry_t;

endpackage

// File: rtl/merge_stage_skid_fifo2.sv
// Two-entry FIFO with 1-bit wrapping pointers; pushes when full and pops when empty are ignored.
module skid_fifo2 #(
  parameter type entry_t = merge_pkg::entry_t
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       push,
  input  logic       pop,
  input  entry_t     wr_entry,
  output entry_t     rd_entry,
  output logic [1:0] count
);

  entry_t mem [2];
  logic   wr_ptr;
  logic   rd_ptr;
  logic   push_ok;
  logic   pop_ok;

  assign push_ok  = push && (count != 2'd2);
  assign pop_ok   = pop && (count != 2'd0);
  assign rd_entry = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (reset) begin
      count  <= '0;
      wr_ptr <= 1'b0;
      rd_ptr <= 1'b0;
      mem[0] <= '0;
      mem[1] <= '0;
    end else begin
      if (push_ok) begin
        mem[wr_ptr] <= wr_entry;
        wr_ptr      <= ~wr_ptr;
      end
      if (pop_ok) begin
        rd_ptr <= ~rd_ptr;
      end
      case ({push_ok, pop_ok})
        2'b10:   count <= count + 2'd1;
        2'b01:   count <= count - 2'd1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/merge_stage.sv
// Selects one of two sources into a 2-entry buffer; unchosen source is always stalled.
// Optional per-source push counters via macro MERGE_STAGE_GRANT_COUNT_EN.
module merge_stage
  import merge_pkg::*;
#(
  parameter int unsigned DATA_W = DATA_W_DEFAULT
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              in_choice,
  input  logic              in_valid_1,
  input  logic [DATA_W-1:0] in_data_1,
  input  logic              in_valid_2,
  input  logic [DATA_W-1:0] in_data_2,
  input  logic              in_down_ready,
  output logic              out_ready,
  output logic              out_stall_1,
  output logic              out_stall_2,
  output logic              out_valid,
  output logic [DATA_W-1:0] out_data,
  output logic              out_src
`ifdef MERGE_STAGE_GRANT_COUNT_EN
  ,
  output logic [15:0]       out_count_1,
  output logic [15:0]       out_count_2
`endif
);

  // Same layout as merge_pkg::entry_t, sized by this instance's DATA_W.
  typedef struct packed {
    logic              src;
    logic [DATA_W-1:0] data;
  } stage_entry_t;

  logic [1:0]   count;
  stage_entry_t wr_entry;
  stage_entry_t rd_entry;
  logic         sel_valid;
  logic         push;
  logic         pop;

  // out_ready depends only on registered occupancy, never on in_down_ready.
  assign out_ready   = (count < 2'd2);
  assign sel_valid   = in_choice ? in_valid_2 : in_valid_1;
  assign push        = sel_valid && out_ready && !reset;
  assign out_stall_1 = !(push && (in_choice == SRC_1));
  assign out_stall_2 = !(push && (in_choice == SRC_2));

  assign out_valid = (count != 2'd0);
  assign pop       = out_valid && in_down_ready;
  assign out_data  = rd_entry.data;
  assign out_src   = rd_entry.src;

  always_comb begin
    wr_entry      = '0;
    wr_entry.src  = in_choice;
    wr_entry.data = in_choice ? in_data_2 : in_data_1;
  end

  skid_fifo2 #(
    .entry_t (stage_entry_t)
  ) u_fifo (
    .clk      (clk),
    .reset    (reset),
    .push     (push),
    .pop      (pop),
    .wr_entry (wr_entry),
    .rd_entry (rd_entry),
    .count    (count)
  );

`ifdef MERGE_STAGE_GRANT_COUNT_EN
  logic [15:0] grant_cnt_1;
  logic [15:0] grant_cnt_2;

  always_ff @(posedge clk) begin
    if (reset) begin
      grant_cnt_1 <= '0;
      grant_cnt_2 <= '0;
    end else if (push) begin
      if (in_choice == SRC_1 && grant_cnt_1 != '1) grant_cnt_1 <= grant_cnt_1 + 16'd1;
      if (in_choice == SRC_2 && grant_cnt_2 != '1) grant_cnt_2 <= grant_cnt_2 + 16'd1;
    end
  end

  assign out_count_1 = grant_cnt_1;
  assign out_count_2 = grant_cnt_2;
`endif

endmodule

// File: tb/tb_merge_stage.sv
// Scoreboard bench for merge_stage: accepted beats are queued and compared as they leave.
module tb_merge_stage;
  import merge_pkg::*;

  localparam int unsigned DW = 32;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          in_choice = 1'b0;
  logic          in_valid_1 = 1'b0;
  logic [DW-1:0] in_data_1 = '0;
  logic          in_valid_2 = 1'b0;
  logic [DW-1:0] in_data_2 = '0;
  logic          in_down_ready = 1'b0;
  logic          out_ready;
  logic          out_stall_1;
  logic          out_stall_2;
  logic          out_valid;
  logic [DW-1:0] out_data;
  logic          out_src;
`ifdef MERGE_STAGE_GRANT_COUNT_EN
  logic [15:0]   out_count_1;
  logic [15:0]   out_count_2;
`endif

  int unsigned n_checks = 0;
  int unsigned n_errors = 0;
  entry_t      sb[$];

  always #5 clk = ~clk;

  merge_stage #(.DATA_W(DW)) dut (
    .clk           (clk),
    .reset         (reset),
    .in_choice     (in_choice),
    .in_valid_1    (in_valid_1),
    .in_data_1     (in_data_1),
    .in_valid_2    (in_valid_2),
    .in_data_2     (in_data_2),
    .in_down_ready (in_down_ready),
    .out_ready     (out_ready),
    .out_stall_1   (out_stall_1),
    .out_stall_2   (out_stall_2),
    .out_valid     (out_valid),
    .out_data      (out_data),
    .out_src       (out_src)
`ifdef MERGE_STAGE_GRANT_COUNT_EN
    ,
    .out_count_1   (out_count_1),
    .out_count_2   (out_count_2)
`endif
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // One clock: drive at negedge, check combinational outputs, advance model at posedge, check registered outputs.
  task automatic step(input logic rst, input logic ch, input logic v1, input logic [DW-1:0] d1,
                      input logic v2, input logic [DW-1:0] d2, input logic dr);
    int unsigned n;
    logic        exp_push;
    entry_t      e;
    reset = rst; in_choice = ch; in_valid_1 = v1; in_data_1 = d1;
    in_valid_2 = v2; in_data_2 = d2; in_down_ready = dr;
    #1;
    n        = sb.size();
    exp_push = !rst && (ch ? v2 : v1) && (n < 2);
    if (rst) begin
      check("stall_1_rst", out_stall_1, 1'b1);
      check("stall_2_rst", out_stall_2, 1'b1);
    end else begin
      check("ready", out_ready, n < 2);
      check("stall_1", out_stall_1, !(exp_push && !ch));
      check("stall_2", out_stall_2, !(exp_push && ch));
      if (n != 0 && dr) begin
        check("pop_data", out_data, sb[0].data);
        check("pop_src", out_src, sb[0].src);
      end
    end
    @(posedge clk);
    if (rst) begin
      sb.delete();
    end else begin
      if (n != 0 && dr) void'(sb.pop_front());
      if (exp_push) begin
        e.src  = ch;
        e.data = ch ? d2 : d1;
        sb.push_back(e);
      end
    end
    #1;
    check("valid", out_valid, sb.size() != 0);
    check("ready_q", out_ready, sb.size() < 2);
    if (sb.size() != 0) begin
      check("head_data", out_data, sb[0].data);
      check("head_src", out_src, sb[0].src);
    end
    @(negedge clk);
  endtask

  task automatic idle(input logic dr);
    step(1'b0, 1'b0, 1'b0, '0, 1'b0, '0, dr);
  endtask

  initial begin
    @(negedge clk);
    // reset with a valid source present: no push, both stalled
    step(1'b1, 1'b0, 1'b1, 32'hDEAD, 1'b1, 32'hBEEF, 1'b1);
    step(1'b1, 1'b1, 1'b1, 32'hDEAD, 1'b1, 32'hBEEF, 1'b0);
    check("rst_valid", out_valid, 1'b0);
    check("rst_ready", out_ready, 1'b1);
    check("rst_data", out_data, '0);
    check("rst_src", out_src, 1'b0);

    // single push from source 1
    step(1'b0, 1'b0, 1'b1, 32'hA5, 1'b0, 32'h0, 1'b0);
    check("single_valid", out_valid, 1'b1);
    check("single_data", out_data, 32'hA5);
    check("single_src", out_src, 1'b0);
    idle(1'b1);

    // fill with downstream blocked, then drain in order
    step(1'b0, 1'b1, 1'b0, 32'h0, 1'b1, 32'h11, 1'b0);
    step(1'b0, 1'b0, 1'b1, 32'h22, 1'b0, 32'h0, 1'b0);
    step(1'b0, 1'b0, 1'b1, 32'h33, 1'b1, 32'h44, 1'b0);
    check("full_ready", out_ready, 1'b0);
    step(1'b0, 1'b1, 1'b1, 32'h33, 1'b1, 32'h44, 1'b1);
    idle(1'b1);
    idle(1'b1);
    check("drained", out_valid, 1'b0);

    // throughput at occupancy 1
    step(1'b0, 1'b0, 1'b1, 32'h100, 1'b0, 32'h0, 1'b0);
    for (int unsigned i = 0; i < 8; i++) begin
      step(1'b0, i[0], 1'b1, 32'h200 + i, 1'b1, 32'h300 + i, 1'b1);
      check("tput_count1", {out_valid, out_ready}, 2'b11);
    end
    idle(1'b1);
    idle(1'b1);

    // mid-operation reset with two beats buffered
    step(1'b0, 1'b0, 1'b1, 32'h55, 1'b0, 32'h0, 1'b0);
    step(1'b0, 1'b1, 1'b0, 32'h0, 1'b1, 32'h66, 1'b0);
    step(1'b1, 1'b0, 1'b1, 32'h77, 1'b0, 32'h0, 1'b1);
    check("midrst_valid", out_valid, 1'b0);
    check("midrst_ready", out_ready, 1'b1);
    idle(1'b1);
    idle(1'b1);

    // random traffic
    for (int unsigned i = 0; i < 60; i++) begin
      step(1'b0, 1'($urandom), 1'($urandom), $urandom, 1'($urandom), $urandom, 1'($urandom));
    end
    for (int unsigned i = 0; i < 3; i++) idle(1'b1);

`ifdef MERGE_STAGE_GRANT_COUNT_EN
    step(1'b1, 1'b0, 1'b0, '0, 1'b0, '0, 1'b1);
    for (int unsigned i = 0; i < 3; i++) step(1'b0, 1'b0, 1'b1, 32'h10 + i, 1'b0, '0, 1'b1);
    for (int unsigned i = 0; i < 5; i++) step(1'b0, 1'b1, 1'b0, '0, 1'b1, 32'h20 + i, 1'b1);
    check("count_1", out_count_1, 16'd3);
    check("count_2", out_count_2, 16'd5);
    idle(1'b1);
    force dut.grant_cnt_1 = 16'hFFFE;
    force dut.grant_cnt_2 = 16'hFFFE;
    @(posedge clk);
    #1;
    release dut.grant_cnt_1;
    release dut.grant_cnt_2;
    @(negedge clk);
    for (int unsigned i = 0; i < 3; i++) step(1'b0, 1'b0, 1'b1, 32'h30 + i, 1'b0, '0, 1'b1);
    for (int unsigned i = 0; i < 3; i++) step(1'b0, 1'b1, 1'b0, '0, 1'b1, 32'h40 + i, 1'b1);
    check("sat_1", out_count_1, 16'hFFFF);
    check("sat_2", out_count_2, 16'hFFFF);
    idle(1'b1);
`endif

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/merge_stage.md
MERGE_STAGE -- requirements
Module: merge_stage

Interface
REQ-001 SHALL have parameter DATA_W, default 32, payload width in bits.
REQ-002 SHALL have port clk  input  1  sole clock; all state updates on rising edge.
REQ-003 SHALL have port reset  input  1  synchronous, active-high reset, sampled on rising clk.
REQ-004 SHALL have port in_choice  input  1  arbiter selection: 0 = source 1, 1 = source 2.
REQ-005 SHALL have port in_valid_1  input  1  source 1 payload valid.
REQ-006 SHALL have port in_data_1  input  DATA_W  source 1 payload.
REQ-007 SHALL have port in_valid_2  input  1  source 2 payload valid.
REQ-008 SHALL have port in_data_2  input  DATA_W  source 2 payload.
REQ-009 SHALL have port in_down_ready  input  1  downstream consumer ready.
REQ-010 SHALL have port out_ready  output  1  buffer can accept; returned to the arbiter as its ready.
REQ-011 SHALL have port out_stall_1  output  1  source 1 must hold its payload this cycle.
REQ-012 SHALL have port out_stall_2  output  1  source 2 must hold its payload this cycle.
REQ-013 SHALL have port out_valid  output  1  buffered beat available downstream.
REQ-014 SHALL have port out_data  output  DATA_W  head-of-buffer payload.
REQ-015 SHALL have port out_src  output  1  head beat origin: 0 = source 1, 1 = source 2.

Function
REQ-016 SHALL use a 2-entry FIFO of {src, data}, with a 2-bit occupancy count (0..2) and 1-bit read/write pointers that wrap 1->0.
REQ-017 SHALL drive out_ready = (count < 2), from registered state only, with no combinational path from in_down_ready.
REQ-018 SHALL compute sel_valid = in_choice ? in_valid_2 : in_valid_1 and push = sel_valid && out_ready.
REQ-019 SHALL drive out_stall_1 = !(push && !in_choice) and out_stall_2 = !(push && in_choice); the unchosen source is always stalled.
REQ-020 SHALL define pop = out_valid && in_down_ready, with out_valid = (count != 0) and out_data/out_src taken from the entry at the read pointer.
REQ-021 SHALL make a pushed beat visible on out_valid on the cycle after the accepting edge (latency 1); there is no bypass.
REQ-022 SHALL handle push and pop in the same cycle at count 1 by leaving count at 1 and advancing both pointers.
REQ-023 SHALL never push at count 2, because out_ready = 0 there, even if a pop occurs in the same cycle.
REQ-024 SHALL ignore a pop request at count 0 (pointers and count unchanged).
REQ-025 SHALL deliver beats in strict acceptance order, with out_data held stable while out_valid && !in_down_ready.

Reset
REQ-026 SHALL, on reset, set count = 0, both pointers = 0, out_valid = 0, out_ready = 1, out_src = 0 and out_data = 0.
REQ-027 SHALL discard any buffered beats when reset asserts mid-operation and assert no push on that edge; out_stall_1 = out_stall_2 = 1 while reset is high.

Configuration
REQ-028 SHALL, when macro MERGE_STAGE_GRANT_COUNT_EN is defined, add output ports out_count_1 and out_count_2 (16 bits each), which count pushes per source, saturate at 0xFFFF and reset to 0.
REQ-029 SHALL, when MERGE_STAGE_GRANT_COUNT_EN is undefined, omit those ports and counters, with all other behaviour identical.

Structure
REQ-030 SHALL place the DATA_W default, the constants SRC_1 = 0 and SRC_2 = 1, and the FIFO entry typedef {src, data} in shared package merge_pkg.
REQ-031 SHALL implement the FIFO as sub-module skid_fifo2 (push/pop/entry/count), with the selection, stall and counter logic in merge_stage.

Verification
REQ-032 SHALL cover reset: after reset, out_valid = 0, out_ready = 1, out_stall_1 = out_stall_2 = 1 while reset is high.
REQ-033 SHALL cover single push: in_choice = 0, in_valid_1 = 1, in_data_1 = 0xA5 -> out_stall_1 = 0 and out_stall_2 = 1 in that cycle; next cycle out_valid = 1, out_data = 0xA5, out_src = 0.
REQ-034 SHALL cover fill: in_down_ready = 0, push 0x11 (src 2) then 0x22 (src 1) -> out_ready = 0 and both stalls = 1 on the third cycle; then in_down_ready = 1 yields 0x11/src 1 then 0x22/src 0.
REQ-035 SHALL cover throughput: count = 1 with continuous push and pop for 8 cycles -> one beat per cycle, count stays 1, order preserved.
REQ-036 SHALL cover mid-operation reset: reset with count = 2 -> next cycle count = 0, out_valid = 0, no stale beat emitted afterwards.
REQ-037 SHALL cover counters: with MERGE_STAGE_GRANT_COUNT_EN defined, 3 source-1 and 5 source-2 pushes -> out_count_1 = 3, out_count_2 = 5; a preload of 0xFFFE plus 2 pushes saturates at 0xFFFF.
